// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR gearbox family (serializer now, deserializer later).
package ddr_pkg;

  localparam bit ORDER_MSB = 1'b1;
  localparam bit ORDER_LSB = 1'b0;

  // Constant-foldable ceil(log2(v)); returns at least 1 so counters never collapse to zero width.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ddr_tx_hold.sv
// Single-entry input buffer for the DDR serializer: holds one accepted word until the shifter takes it.
module ddr_tx_hold
  import ddr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  input  logic             dvalid,
  input  logic             load,
  output logic             dready,
  output logic             accept,
  output logic             hold_full,
  output logic [WIDTH-1:0] hold_data
);

  // Ready is purely a function of occupancy, enable and reset so upstream can rely on it combinationally.
  assign dready = ce & ~rst & ~hold_full;
  assign accept = dvalid & dready;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
    end else if (ce) begin
      if (load) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ce && accept) begin
      hold_data <= din;
    end
  end

endmodule

// File: rtl/ddr_tx_serializer.sv
// Parallel-to-DDR gearbox: buffers one word and emits two bits per clock for an OPPOSITE_EDGE ODDR.
module ddr_tx_serializer
  import ddr_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = ORDER_MSB,
  parameter logic IDLE      = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DVALID,
  output logic             DREADY,
  output logic             D1,
  output logic             D2,
  output logic             DOUT_VALID,
  output logic             BUSY
);

  localparam int PAIRS = WIDTH / 2;
  localparam int CNT_W = clog2(PAIRS + 1);

  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             accept;
  logic             load;

  logic [WIDTH-1:0] sr_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             pair_first;
  logic             pair_second;
  logic [WIDTH-1:0] sr_shifted;

  logic             d1_p1;
  logic             d2_p1;
  logic             vld_p1;

  // Reload while the last pair is leaving so consecutive words run gap-free.
  assign load = hold_full & (cnt_p0 <= CNT_W'(1));

  ddr_tx_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (C),
    .rst      (R),
    .ce       (CE),
    .din      (DIN),
    .dvalid   (DVALID),
    .load     (load),
    .dready   (DREADY),
    .accept   (accept),
    .hold_full(hold_full),
    .hold_data(hold_data)
  );

  always_comb begin
    pair_first  = 1'b0;
    pair_second = 1'b0;
    sr_shifted  = '0;
    if (MSB_FIRST == ORDER_MSB) begin
      pair_first  = sr_p0[WIDTH-1];
      pair_second = sr_p0[WIDTH-2];
      sr_shifted  = sr_p0 << 2;
    end else begin
      pair_first  = sr_p0[0];
      pair_second = sr_p0[1];
      sr_shifted  = sr_p0 >> 2;
    end
  end

  // Stage p0: shifter and remaining-pair counter
  always_ff @(posedge C) begin
    if (R) begin
      sr_p0  <= '0;
      cnt_p0 <= '0;
    end else if (CE) begin
      if (load) begin
        sr_p0  <= hold_data;
        cnt_p0 <= CNT_W'(PAIRS);
      end else if (cnt_p0 != '0) begin
        sr_p0  <= sr_shifted;
        cnt_p0 <= cnt_p0 - CNT_W'(1);
      end
    end
  end

  // Stage p1: registered pin drive towards the ODDR
  always_ff @(posedge C) begin
    if (R) begin
      d1_p1  <= IDLE;
      d2_p1  <= IDLE;
      vld_p1 <= 1'b0;
    end else if (CE) begin
      if (cnt_p0 != '0) begin
        d1_p1  <= pair_first;
        d2_p1  <= pair_second;
        vld_p1 <= 1'b1;
      end else begin
        d1_p1  <= IDLE;
        d2_p1  <= IDLE;
        vld_p1 <= 1'b0;
      end
    end
  end

  assign D1         = d1_p1;
  assign D2         = d2_p1;
  assign DOUT_VALID = vld_p1;
  assign BUSY       = hold_full | (cnt_p0 != '0);

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// Randomized scoreboard bench for ddr_tx_serializer: two instances (MSB/IDLE=0 and LSB/IDLE=1) share stimulus.
module tb_ddr_tx_serializer;

  localparam int W     = 8;
  localparam int PAIRS = W / 2;

  logic       C      = 1'b0;
  logic       R      = 1'b1;
  logic       CE     = 1'b1;
  logic       DVALID = 1'b1;
  logic [7:0] DIN    = 8'h00;

  logic dready_a, d1_a, d2_a, dv_a, busy_a;
  logic dready_b, d1_b, d2_b, dv_b, busy_b;

  always #5 C = ~C;

  ddr_tx_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE(1'b0)) dut_a (
    .C(C), .R(R), .CE(CE), .DIN(DIN), .DVALID(DVALID), .DREADY(dready_a),
    .D1(d1_a), .D2(d2_a), .DOUT_VALID(dv_a), .BUSY(busy_a)
  );

  ddr_tx_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE(1'b1)) dut_b (
    .C(C), .R(R), .CE(CE), .DIN(DIN), .DVALID(DVALID), .DREADY(dready_b),
    .D1(d1_b), .D2(d2_b), .DOUT_VALID(dv_b), .BUSY(busy_b)
  );

  typedef struct {
    logic [7:0] word;
    int         first;
  } ent_t;

  ent_t q[$];
  int   ecnt      = 0;
  int   last_load = -100;
  int   prev_last = -100;
  int   acc_cnt   = 0;
  bit   stalled   = 1'b0;
  bit   rst_edge  = 1'b0;
  bit   started   = 1'b0;
  int   checks    = 0;
  int   errors    = 0;
  int   run       = 0;
  int   max_run   = 0;
  logic exp_prev_d1 [2];
  logic exp_prev_d2 [2];
  logic exp_prev_dv [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (edge %0d, t=%0t)", name, got, exp, ecnt, $time);
    end
  endtask

  // Bit p of the transmit order is DIN[W-1-p] for MSB-first, DIN[p] for LSB-first.
  function automatic logic tx_bit(input logic [7:0] word, input int p, input bit msb);
    return msb ? word[W-1-p] : word[p];
  endfunction

  // Reference model: tracks enabled edges and, per accepted word, the edge of its first pair.
  always @(posedge C) begin
    int ld;
    started = 1'b1;
    if (R) begin
      q.delete();
      last_load = -100;
      prev_last = -100;
      rst_edge  = 1'b1;
      stalled   = 1'b0;
    end else if (!CE) begin
      stalled  = 1'b1;
      rst_edge = 1'b0;
    end else begin
      ecnt++;
      stalled  = 1'b0;
      rst_edge = 1'b0;
      if (DVALID && !(last_load >= ecnt)) begin
        ld        = (ecnt + 1 > prev_last) ? ecnt + 1 : prev_last;
        q.push_back('{word: DIN, first: ld + 1});
        prev_last = ld + 1 + PAIRS - 1;
        last_load = ld;
        acc_cnt++;
      end
    end
  end

  // Monitor: compares both instances against the head of the scoreboard.
  always @(negedge C) begin
    logic od1, od2, odv, obusy, odr, e1, e2, ev, ebusy, idl;
    bit   msb;
    int   p;
    if (started) begin
      if (!rst_edge && !stalled) begin
        while (q.size() > 0 && q[0].first + PAIRS - 1 < ecnt) void'(q.pop_front());
      end
      for (int u = 0; u < 2; u++) begin
        od1   = (u == 0) ? d1_a : d1_b;
        od2   = (u == 0) ? d2_a : d2_b;
        odv   = (u == 0) ? dv_a : dv_b;
        obusy = (u == 0) ? busy_a : busy_b;
        msb   = (u == 0);
        idl   = (u == 0) ? 1'b0 : 1'b1;
        if (rst_edge) begin
          e1 = idl; e2 = idl; ev = 1'b0; ebusy = 1'b0;
        end else if (stalled) begin
          e1 = exp_prev_d1[u]; e2 = exp_prev_d2[u]; ev = exp_prev_dv[u];
          ebusy = (last_load > ecnt) || (prev_last > ecnt);
        end else begin
          ebusy = (last_load > ecnt) || (prev_last > ecnt);
          if (q.size() > 0 && q[0].first <= ecnt) begin
            p  = ecnt - q[0].first;
            e1 = tx_bit(q[0].word, 2 * p, msb);
            e2 = tx_bit(q[0].word, 2 * p + 1, msb);
            ev = 1'b1;
          end else begin
            e1 = idl; e2 = idl; ev = 1'b0;
          end
        end
        chk($sformatf("dout_valid[%0d]", u), odv, ev);
        chk($sformatf("d1[%0d]", u), od1, e1);
        chk($sformatf("d2[%0d]", u), od2, e2);
        chk($sformatf("busy[%0d]", u), obusy, ebusy);
        exp_prev_d1[u] = e1;
        exp_prev_d2[u] = e2;
        exp_prev_dv[u] = ev;
      end
      if (!stalled) begin
        run = dv_a ? run + 1 : 0;
        if (run > max_run) max_run = run;
      end
    end
    #2;
    if (started) begin
      odr = CE && !R && !(last_load > ecnt);
      chk("dready[0]", dready_a, odr);
      chk("dready[1]", dready_b, odr);
    end
  end

  task automatic send(input logic [7:0] word);
    int  n;
    bit  ok;
    @(negedge C); #1;
    DIN    = word;
    DVALID = 1'b1;
    n      = acc_cnt;
    ok     = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge C); #1;
      if (acc_cnt != n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    @(negedge C); #1;
    DVALID = 1'b0;
    repeat (n) @(posedge C);
  endtask

  initial begin
    int seen;
    // Reset held for three edges with DVALID asserted.
    repeat (3) @(posedge C);
    @(negedge C); #1;
    R      = 1'b0;
    DVALID = 1'b0;
    repeat (2) @(posedge C);

    send(8'hA5);
    idle(8);

    max_run = 0;
    run     = 0;
    send(8'hF0);
    send(8'h3C);
    idle(8);
    chk("b2b_run", max_run, 32'd8);

    // CE stall after the second pair.
    send(8'hA5);
    @(negedge C); #1;
    DVALID = 1'b0;
    repeat (3) @(posedge C);
    @(negedge C); #1;
    CE = 1'b0;
    repeat (2) @(posedge C);
    @(negedge C); #1;
    CE = 1'b1;
    idle(8);

    // Reset mid-word with a second word held.
    send(8'hA5);
    send(8'hFF);
    @(negedge C); #1;
    DVALID = 1'b0;
    @(posedge C);
    @(negedge C); #1;
    R = 1'b1;
    @(posedge C);
    @(negedge C); #1;
    R = 1'b0;
    repeat (8) @(posedge C);

    send(8'h01);
    idle(8);

    seen = acc_cnt;
    for (int i = 0; i < 400; i++) begin
      @(negedge C); #1;
      if (DVALID && acc_cnt != seen) DVALID = 1'b0;
      seen = acc_cnt;
      CE   = ($urandom_range(0, 9) != 0);
      R    = ($urandom_range(0, 59) == 0);
      if (!DVALID && $urandom_range(0, 3) != 0) begin
        DVALID = 1'b1;
        DIN    = 8'($urandom);
      end
    end
    @(negedge C); #1;
    R      = 1'b0;
    CE     = 1'b1;
    DVALID = 1'b0;
    repeat (14) @(posedge C);
    @(negedge C);
    #3;
    while (q.size() > 0 && q[0].first + PAIRS - 1 < ecnt) void'(q.pop_front());
    chk("drain", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
